pixel_fb_writer: RTL
====================

# pixel_fb_writer

Consumer end of the rasterizer pixel stream. It accepts the (X, Y) pixel coordinates emitted by the line and filled-triangle engines and clips off-screen pixels. Surviving pixels are buffered in a small FIFO, converted to linear framebuffer addresses, and written through a req/ack memory port. It raises `done` once the producer has finished and every buffered pixel has been written, which lets the sequencer start the next primitive.

## Interface
Parameters:
- `H_RES`, 640, horizontal resolution; also the address row stride.
- `V_RES`, 480, vertical resolution.
- `ADDR_W`, 19, framebuffer address width.
- `COLOR_W`, 8, pixel colour width.
- `FIFO_DEPTH`, 8, number of entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `px_valid`  in  1  a pixel is present on `px_x`/`px_y`.
- `px_x`  in  10  pixel X coordinate (unsigned).
- `px_y`  in  9  pixel Y coordinate (unsigned).
- `px_color`  in  COLOR_W  colour of the current pixel.
- `px_ready`  out  1  block can accept a pixel this cycle.
- `src_finish`  in  1  level signal; producer has emitted its last pixel.
- `mem_req`  out  1  write request to the framebuffer.
- `mem_addr`  out  ADDR_W  write address.
- `mem_data`  out  COLOR_W  write data.
- `mem_ack`  in  1  memory has accepted the current write.
- `done`  out  1  producer finished, FIFO empty, no write outstanding.
- `drop_cnt`  out  16  saturating count of clipped pixels.

## Operation
- **Accept.** A pixel is transferred on a rising edge where `px_valid & px_ready` is high. `px_ready = !fifo_full`; it is not bypassed, even when a pop happens in the same cycle.
- **Clip.** An accepted pixel with `px_x >= H_RES` or `px_y >= V_RES` is discarded.
  - `drop_cnt` increments and saturates at 16'hFFFF.
  - Nothing is pushed to the FIFO.
- **Address.** Address = `px_y*H_RES + px_x`, computed at accept time and truncated to ADDR_W.
  - The default build uses shift-add: (y<<9)+(y<<7)+x.
  - Maximum result is 307199, which fits in 19 bits.
  - The FIFO entry is {addr, color}.
- **FIFO.**
  - Circular buffer with wrap-around read/write pointers and an occupancy counter.
  - A simultaneous push and pop leaves occupancy unchanged.
  - A push while full is impossible by construction.
  - A pop while empty never occurs.
- **Writer FSM.**
  - IDLE: if the FIFO is non-empty, pop the head, register `mem_addr`/`mem_data`, assert `mem_req`, go to REQ.
  - REQ: hold `mem_req`, `mem_addr` and `mem_data` stable until `mem_ack` is sampled high. On ack, deassert `mem_req` and return to IDLE.
  - A `mem_ack` seen while in IDLE is ignored.
- **Done.** Registered: `done <= src_finish & fifo_empty & state==IDLE & !(px_valid & px_ready)`.
  - `done` falls the cycle after any of these conditions drops, for example when a new primitive starts and `src_finish` goes low.
- **Reset.** Asserting `reset`, including mid-transaction:
  - `mem_req` drops immediately (asynchronously).
  - The FIFO is flushed and the FSM returns to IDLE.
  - The pending write is abandoned.

## Timing
- Reset values: `px_ready`=0 while `reset` is high, 1 after release (FIFO empty); `mem_req`=0; `mem_addr`=0; `mem_data`=0; `done`=0; `drop_cnt`=0.
- Latency: a pixel accepted at edge N is in the FIFO after edge N; `mem_req` rises after edge N+1 when the writer is IDLE.
- Throughput: at most one write per 2 cycles (REQ, then one IDLE cycle). With zero-wait ack, sustained input is limited to 1 pixel per 2 cycles once the FIFO fills.
- `mem_ack` is sampled only in REQ; it may arrive as early as the first REQ cycle.
- `done` trails the final ack by 2 cycles: ack edge → IDLE, next edge → `done`.

## Configuration
- `FB_WRITER_DEDUP_EN` defined: the block keeps the last accepted in-range coordinate plus a valid bit.
  - An accepted pixel with identical (x, y) to the previous in-range pixel is discarded: no push, no `drop_cnt` change.
  - The valid bit clears on reset and whenever `src_finish` is high.
- Not defined: every in-range pixel is written, duplicates included.

## Test plan
- Reset, then pixel (5,2) colour 8'h3C with immediate ack → exactly one write, `mem_addr`=1285, `mem_data`=8'h3C; `done` rises 2 cycles after the ack with `src_finish`=1.
- Pixels (639,479) and (640,0), then (0,480) → one write to addr 307199; `drop_cnt`=2.
- Burst of 12 pixels with `mem_ack` held low for 40 cycles → `px_ready` goes 0 after 9 accepts (8 buffered + 1 in REQ); after ack resumes, all 12 addresses are written in input order.
- Reset asserted while in REQ with 3 entries buffered → `mem_req` falls in the same cycle; no further writes after release; `done`=0 until `src_finish`.
- With `FB_WRITER_DEDUP_EN`: stream (10,10), (10,10), (11,10), (10,10) → writes to addresses 6410, 6411, 6410; without the macro → 4 writes.
- `drop_cnt` forced near 16'hFFFF by 65540 off-screen pixels → saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module : pixel_fb_writer
// Clips rasterizer pixels, buffers survivors in a FIFO as {addr, color} and
// writes them over a req/ack port. Optional macro: FB_WRITER_DEDUP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module pixel_fb_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               px_valid,
    input  logic [9:0]         px_x,
    input  logic [8:0]         px_y,
    input  logic [COLOR_W-1:0] px_color,
    output logic               px_ready,
    input  logic               src_finish,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ack,
    output logic               done,
    output logic [15:0]        drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + COLOR_W;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      c_H_RES = 32'(H_RES);
    localparam logic [31:0]      c_V_RES = 32'(V_RES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [0:0]         r_state;
    logic               r_req;
    logic [ADDR_W-1:0]  r_addr;
    logic [COLOR_W-1:0] r_data;
    logic               r_done;
    logic [15:0]        r_drop;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_in_range;
    logic              w_dup;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_addr;
    logic [ENT_W-1:0]  w_head;

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign px_ready   = !w_full && !reset;
    assign w_accept   = px_valid && px_ready;
    assign w_in_range = (32'(px_x) < c_H_RES) && (32'(px_y) < c_V_RES);
    assign w_push     = w_accept && w_in_range && !w_dup;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_head     = r_mem[r_rptr];

    generate
        if (H_RES == 640) begin : g_addr_shift
            assign w_addr = ADDR_W'((32'(px_y) << 9) + (32'(px_y) << 7) + 32'(px_x));
        end else begin : g_addr_mul
            assign w_addr = ADDR_W'(32'(px_y) * c_H_RES + 32'(px_x));
        end
    endgenerate

`ifdef FB_WRITER_DEDUP_EN
    logic [9:0] r_last_x;
    logic [8:0] r_last_y;
    logic       r_last_vld;

    assign w_dup = r_last_vld && (px_x == r_last_x) && (px_y == r_last_y);

    // Finishing a primitive forgets the last coordinate so the next one starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_x   <= '0;
            r_last_y   <= '0;
            r_last_vld <= 1'b0;
        end else if (src_finish) begin
            r_last_vld <= 1'b0;
        end else if (w_accept && w_in_range) begin
            r_last_x   <= px_x;
            r_last_y   <= px_y;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_addr, px_color};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        {r_addr, r_data} <= w_head;
                        r_req            <= 1'b1;
                        r_state          <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_drop <= '0;
        end else begin
            r_done <= src_finish && w_empty && (r_state == S_IDLE) && !w_accept;
            if (w_accept && !w_in_range && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign mem_req  = r_req;
    assign mem_addr = r_addr;
    assign mem_data = r_data;
    assign done     = r_done;
    assign drop_cnt = r_drop;

endmodule
`default_nettype wire
